// File: rtl/apb_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_master: single-outstanding APB requester, SETUP/ACCESS from valid/ready.
// Optional wait-state abort via APB_TIMEOUT_EN.   Rev 1.0
// ----------------------------------------------------------------------------
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk_i,
  input  logic              preset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              abort;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       rsp_err_q;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == S_SETUP) begin
      wait_cnt_d = 8'd0;
    end else if (state_q == S_ACCESS && !pready_i) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // pready high on the limit edge wins: abort only fires while still stalled
  assign abort = (state_q == S_ACCESS) && !pready_i && (wait_cnt_q == C_WAIT_LAST);

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      wait_cnt_q <= 8'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rsp_err_q  <= abort;
    end
  end

  assign rsp_err_o = rsp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign abort          = 1'b0;
  assign rsp_err_o      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          psel_d   = 1'b1;
          pwrite_d = cmd_write_i;
          paddr_d  = cmd_addr_i;
          pwdata_d = cmd_wdata_i;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready_i || abort) begin
          state_d     = S_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          rsp_valid_d = 1'b1;
          if (pready_i && !pwrite_q) begin
            rsp_rdata_d = prdata_i;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_apb_master: directed + randomized bench with a transaction-level model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_apb_master;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 4;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;

  logic          cmd_ready, rsp_valid, rsp_err, busy, psel, penable, pwrite;
  logic [DW-1:0] rsp_rdata, pwdata;
  logic [AW-1:0] paddr;

  int tests = 0;
  int fails = 0;
  int rsp_seen = 0;
  bit rand_on = 1'b0;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk_i(pclk), .preset_i(preset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .busy_o(busy), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a transfer is SETUP, then ACCESS cycles until
  // pready (or TO stalled cycles), then one response cycle back in idle.
  bit            m_busy = 0, m_write = 0, m_rsp = 0, m_err = 0;
  int            m_age = 0, m_lows = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;

  always @(negedge pclk) begin
    bit n_rsp, n_err;
    if (preset) begin
      m_busy = 0; m_write = 0; m_rsp = 0; m_err = 0; m_age = 0; m_lows = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      chk("psel", psel, m_busy);
      chk("penable", penable, m_busy && m_age >= 1);
      chk("pwrite", pwrite, m_busy ? m_write : 1'b0);
      chk("paddr", paddr, m_addr);
      chk("pwdata", pwdata, m_wdata);
      chk("busy", busy, m_busy);
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("rsp_valid", rsp_valid, m_rsp);
      chk("rsp_err", rsp_err, m_err);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      if (rsp_valid) rsp_seen++;
      n_rsp = 0; n_err = 0;
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy = 1; m_age = 0; m_lows = 0;
          m_write = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (pready) begin
        m_busy = 0; n_rsp = 1;
        if (!m_write) m_rdata = prdata;
      end else begin
        m_lows++;
`ifdef APB_TIMEOUT_EN
        if (m_lows == TO) begin
          m_busy = 0; n_rsp = 1; n_err = 1;
        end
`endif
      end
      m_rsp = n_rsp; m_err = n_err;
    end
  end

  always @(posedge pclk) begin
    if (rand_on) begin
      #1;
      pready = ($urandom_range(0, 2) != 0);
      prdata = DW'($urandom);
    end
  end

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
  endtask

  // Counts cycles from the SETUP cycle to the response cycle.
  task automatic wait_rsp(output int lat, output bit got);
    lat = 0; got = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge pclk);
      if (rsp_valid) begin
        got = 1;
        break;
      end
      tick;
      lat++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, snap;
    bit got, r;

    repeat (3) tick;
    @(negedge pclk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_paddr", paddr, 0);
    tick;
    preset = 1'b0;
    @(negedge pclk);
    chk("rst_cmd_ready", cmd_ready, 1);
    tick;

    // zero-wait write
    pready = 1'b1;
    issue(1'b1, 8'h12, 8'hA5);
    @(negedge pclk);
    chk("zw_setup_psel", psel, 1);
    chk("zw_setup_penable", penable, 0);
    tick;
    @(negedge pclk);
    chk("zw_access_penable", penable, 1);
    chk("zw_paddr", paddr, 8'h12);
    chk("zw_pwdata", pwdata, 8'hA5);
    tick;
    @(negedge pclk);
    chk("zw_rsp_valid", rsp_valid, 1);
    chk("zw_rsp_err", rsp_err, 0);
    chk("zw_psel_drop", psel, 0);
    tick;

    // zero-wait read, then a write must not disturb rsp_rdata
    prdata = 8'hA5;
    issue(1'b0, 8'h12, 8'h00);
    wait_rsp(lat, got);
    chk("zr_got", got, 1);
    chk("zr_latency", lat, 2);
    chk("zr_rdata", rsp_rdata, 8'hA5);
    tick;
    prdata = 8'h77;
    issue(1'b1, 8'h34, 8'h5A);
    wait_rsp(lat, got);
    chk("wr_keeps_rdata", rsp_rdata, 8'hA5);
    tick;

    // three wait states
    pready = 1'b0; prdata = 8'h5C;
    issue(1'b0, 8'h3F, 8'h00);
    fork
      begin repeat (4) tick; pready = 1'b1; end
      wait_rsp(lat, got);
    join
    chk("ws_latency", lat, 5);
    chk("ws_rdata", rsp_rdata, 8'h5C);
    tick;

    // back-to-back with cmd_valid held
    pready = 1'b1; prdata = 8'hC3;
    cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 8'h11; cmd_valid = 1'b1;
    tick;
    cmd_write = 1'b0; cmd_addr = 8'h21;
    @(negedge pclk); chk("b2b_ready_setup", cmd_ready, 0);
    tick;
    @(negedge pclk); chk("b2b_ready_access", cmd_ready, 0);
    tick;
    @(negedge pclk);
    chk("b2b_rsp1", rsp_valid, 1);
    chk("b2b_ready_rsp", cmd_ready, 1);
    chk("b2b_psel_gap", psel, 0);
    tick;
    cmd_valid = 1'b0;
    @(negedge pclk); chk("b2b_psel2", psel, 1);
    wait_rsp(lat, got);
    chk("b2b_got2", got, 1);
    chk("b2b_rdata2", rsp_rdata, 8'hC3);
    tick;

    // reset while stalled in ACCESS
    pready = 1'b0;
    issue(1'b0, 8'h40, 8'h00);
    tick;
    @(negedge pclk);
    chk("mr_penable_before", penable, 1);
    snap = rsp_seen;
    #2 preset = 1'b1;
    #1;
    chk("mr_psel_async", psel, 0);
    chk("mr_penable_async", penable, 0);
    repeat (3) tick;
    preset = 1'b0;
    repeat (5) tick;
    chk("mr_no_rsp", rsp_seen, snap);
    @(negedge pclk); chk("mr_cmd_ready", cmd_ready, 1);
    tick;
    pready = 1'b1; prdata = 8'h9E;
    issue(1'b0, 8'h41, 8'h00);
    wait_rsp(lat, got);
    chk("mr_recover_got", got, 1);
    chk("mr_recover_rdata", rsp_rdata, 8'h9E);
    tick;

    // randomized traffic
    rand_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
      cmd_valid = 1'b1;
      r = 0;
      for (int k = 0; k < 300; k++) begin
        @(negedge pclk);
        r = cmd_ready;
        tick;
        if (r) break;
      end
      if (!r) chk("rand_accept", 0, 1);
      if ($urandom_range(0, 1) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(0, 3)) tick;
      end
    end
    cmd_valid = 1'b0;
    rand_on = 1'b0;
    tick;
    pready = 1'b1;
    repeat (8) tick;

`ifdef APB_TIMEOUT_EN
    pready = 1'b0;
    issue(1'b0, 8'h55, 8'h00);
    wait_rsp(lat, got);
    chk("to_got", got, 1);
    chk("to_latency", lat, 5);
    chk("to_err", rsp_err, 1);
    tick;
    prdata = 8'h3A;
    issue(1'b0, 8'h56, 8'h00);
    fork
      begin repeat (4) tick; pready = 1'b1; end
      wait_rsp(lat, got);
    join
    chk("to_edge_err", rsp_err, 0);
    chk("to_edge_rdata", rsp_rdata, 8'h3A);
    tick;
`else
    pready = 1'b0;
    issue(1'b0, 8'h55, 8'h00);
    snap = rsp_seen;
    repeat (100) tick;
    chk("nto_no_rsp", rsp_seen, snap);
    @(negedge pclk);
    chk("nto_still_access", penable, 1);
    tick;
    preset = 1'b1;
    tick;
    preset = 1'b0;
    tick;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
